fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit lab CPU; sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory address. Captures the combinational read data into an IF/ID register, which it presents to decode with a valid/ready handshake.
- Handles control-flow redirects from execute and halts at end of program.

Parameters:
ADDR_W, 8, PC / memory address width
INSTR_W, 8, instruction width
RESET_PC, 0, PC value after reset
PROG_LEN, 32, number of valid instruction words (1..2^ADDR_W); fetch halts when PC >= PROG_LEN

Ports:
clk  in  1  clock; one clock for the whole block
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  address to instruction memory (combinational read)
imem_data  in  INSTR_W  instruction returned for imem_addr in the same cycle
out_valid  out  1  IF/ID register holds a valid instruction
out_ready  in  1  decode accepts the instruction this cycle
out_instr  out  INSTR_W  fetched instruction
out_pc  out  ADDR_W  address of out_instr
redirect  in  1  execute-stage control-flow change
redirect_pc  in  ADDR_W  new fetch address when redirect=1
halted  out  1  fetch stopped at end of program

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, state=RUN.
- imem_addr = pc, driven combinationally from the PC register.
- States:
  - RUN: fetching.
  - HALT: halted=1, no fetch.
- Fetch opportunity: state=RUN, redirect=0, and (out_valid=0 or out_ready=1).
  - If pc < PROG_LEN (compare at ADDR_W+1 bits): out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=next_pc.
  - Otherwise: state<=HALT. out_valid<=0 if out_ready=1, else hold.
- next_pc = pc+1, wrapping mod 2^ADDR_W.
- Stall (out_valid=1, out_ready=0, redirect=0): pc, out_instr, out_pc and out_valid all hold; imem_addr stable.
- Drain in HALT: out_ready=1 with out_valid=1 clears out_valid; nothing new is loaded.
- Redirect has the highest priority after reset:
  - pc<=redirect_pc, out_valid<=0 (the held instruction is younger than the redirecting one and is discarded), state<=RUN, halted<=0.
  - out_ready is ignored in that cycle.
  - No fetch occurs in the redirect cycle; the first instruction from redirect_pc is valid after the following edge.
- Latency: 1 cycle, address to out_instr. After reset deasserts, out_valid rises at the first edge.
- Throughput: 1 instruction/cycle while out_ready=1.
- Reset mid-operation: reset dominates redirect and the handshake; all state returns to reset values at that edge.

Optional Feature:
- Macro FETCH_JUMP_EN.
- Defined: early jump in fetch. When an instruction with imem_data[7:6]=2'b11 is loaded, next_pc = pc+1+sign_extend(imem_data[5:0]), wrapping mod 2^ADDR_W. The instruction is still delivered unchanged. Redirect still overrides.
- Undefined: next_pc is always pc+1; jumps are resolved only via redirect.

Test Plan:
- Sequential fetch: imem[0..2]=0x49,0x61,0x45, release reset, out_ready=1 -> consecutive cycles give (out_pc,out_instr)=(0,0x49),(1,0x61),(2,0x45), out_valid=1 throughout.
- Stall: hold out_ready=0 for 3 cycles while out_pc=1 -> out_instr=0x61, out_pc=1, imem_addr=2 all stable. Raise out_ready -> next output (2,0x45), no skip or duplicate.
- Redirect: imem[8]=0x7B; pulse redirect=1, redirect_pc=8 while out_valid=1, out_ready=0 -> next cycle out_valid=0. The following cycle gives out_pc=8, out_instr=0x7B.
- Halt:
  - PROG_LEN=11, imem[10]=0xC3, FETCH_JUMP_EN undefined, out_ready=1 -> after (10,0xC3), out_valid=0 and halted=1.
  - Then redirect to 0 -> halted=0, and (0,0x49) follows.
- Early jump: FETCH_JUMP_EN defined, PROG_LEN=32, fetch 0xC3 at pc 10 -> next out_pc=14. With PROG_LEN=11, halted=1 instead.
- Reset mid-stall: reset=1 with out_valid=1, out_ready=0 -> after one edge out_valid=0, imem_addr=0, halted=0. After release, (0,0x49) appears.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage, instruction memory,
// decode and execute.
//   imem_addr   - fetch address to instruction memory (combinational read)
//   imem_data   - instruction returned for imem_addr in the same cycle
//   out_valid   - IF/ID register holds a valid instruction
//   out_ready   - decode accepts the instruction this cycle
//   out_instr   - fetched instruction
//   out_pc      - address of out_instr
//   redirect    - execute-stage control-flow change
//   redirect_pc - new fetch address when redirect=1
//   halted      - fetch stopped at end of program
// Modport master is the fetch unit; slave is everything around it.
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect,
    output redirect_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 8-bit lab CPU.
// Owns the PC, drives the instruction-memory address, captures the read data
// into an IF/ID register and hands it to decode with valid/ready. Execute can
// redirect the PC; fetch halts once the PC leaves the program.
// Ports:
//   clk   - single clock
//   reset - synchronous, active-high
//   bus   - fetch_unit_if.master (memory, IF/ID handshake, redirect, halted)
// Optional build macro FETCH_JUMP_EN: instructions with bits [7:6]=2'b11 are
// treated as relative jumps at fetch time (next_pc = pc+1+sext(bits[5:0])).
//
// state | meaning
// ------+------------------------------------------------
// RUN   | fetching one instruction per cycle when allowed
// HALT  | end of program reached; halted=1, no fetch
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      bus
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               pc_in_prog;
  logic               slot_free;

  assign bus.imem_addr = pc;

  // Extra bit so PROG_LEN = 2^ADDR_W still compares correctly.
  assign pc_in_prog = ({1'b0, pc} < PROG_END);

  // IF/ID register can take a new instruction this cycle.
  assign slot_free = !bus.out_valid || bus.out_ready;

`ifdef FETCH_JUMP_EN
  logic [ADDR_W-1:0] jump_off;
  logic              is_jump;

  assign is_jump  = (bus.imem_data[7:6] == 2'b11);
  assign jump_off = {{(ADDR_W-6){bus.imem_data[5]}}, bus.imem_data[5:0]};

  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (is_jump)
      next_pc = pc + ADDR_W'(1) + jump_off;
  end
`else
  always_comb begin
    next_pc = pc + ADDR_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= PC_INIT;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_pc    <= '0;
      bus.halted    <= 1'b0;
    end else if (bus.redirect) begin
      // The held instruction is younger than the redirecting one: drop it.
      state         <= RUN;
      pc            <= bus.redirect_pc;
      bus.out_valid <= 1'b0;
      bus.halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            if (pc_in_prog) begin
              bus.out_instr <= bus.imem_data;
              bus.out_pc    <= pc;
              bus.out_valid <= 1'b1;
              pc            <= next_pc;
            end else begin
              state      <= HALT;
              bus.halted <= 1'b1;
              if (bus.out_ready)
                bus.out_valid <= 1'b0;
            end
          end
        end
        HALT: begin
          if (bus.out_ready)
            bus.out_valid <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  logic clk;
  logic reset;
  logic [7:0] mem [256];

  int total;
  int bad;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(0),
    .PROG_LEN(11)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pc, input logic [7:0] instr);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".pc"},    32'(bus.out_pc),    32'(pc));
    chk({tag, ".instr"}, 32'(bus.out_instr), 32'(instr));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h49;
    mem[1] = 8'h61;
    mem[2] = 8'h45;
    for (int i = 3; i < 10; i++) mem[i] = 8'(8'h10 + i);
    mem[8]  = 8'h7B;
    mem[10] = 8'hC3;

    reset           = 1'b1;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();

    // reset values
    chk("rst.valid",  32'(bus.out_valid), 32'd0);
    chk("rst.halted", 32'(bus.halted),    32'd0);
    chk("rst.addr",   32'(bus.imem_addr), 32'd0);
    chk("rst.instr",  32'(bus.out_instr), 32'd0);
    chk("rst.pc",     32'(bus.out_pc),    32'd0);

    // sequential fetch
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_out("seq0", 8'd0, 8'h49);
    step();
    chk_out("seq1", 8'd1, 8'h61);

    // stall three cycles on (1,0x61)
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 8'd1, 8'h61);
      chk("stall.addr", 32'(bus.imem_addr), 32'd2);
    end
    bus.out_ready = 1'b1;
    step();
    chk_out("unstall", 8'd2, 8'h45);
    step();
    chk_out("seq3", 8'd3, 8'h13);

    // redirect while stalled on a valid instruction
    bus.out_ready = 1'b0;
    step();
    chk_out("hold3", 8'd3, 8'h13);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'd8;
    step();
    chk("redir.valid", 32'(bus.out_valid), 32'd0);
    chk("redir.addr",  32'(bus.imem_addr), 32'd8);
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_out("redir8", 8'd8, 8'h7B);
    step();
    chk_out("seq9", 8'd9, 8'h19);

    // last word of the program, then halt
    step();
    chk_out("last", 8'd10, 8'hC3);
`ifdef FETCH_JUMP_EN
    chk("jump.addr", 32'(bus.imem_addr), 32'd14);
`else
    chk("nojump.addr", 32'(bus.imem_addr), 32'd11);
`endif
    chk("last.halted", 32'(bus.halted), 32'd0);
    step();
    chk("halt.valid",  32'(bus.out_valid), 32'd0);
    chk("halt.halted", 32'(bus.halted),    32'd1);
    step();
    chk("halt2.valid",  32'(bus.out_valid), 32'd0);
    chk("halt2.halted", 32'(bus.halted),    32'd1);

    // redirect out of HALT
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'd0;
    step();
    chk("unhalt.halted", 32'(bus.halted),    32'd0);
    chk("unhalt.valid",  32'(bus.out_valid), 32'd0);
    chk("unhalt.addr",   32'(bus.imem_addr), 32'd0);
    bus.redirect = 1'b0;
    step();
    chk_out("restart0", 8'd0, 8'h49);
    step();
    chk_out("restart1", 8'd1, 8'h61);

    // reset while stalled
    bus.out_ready = 1'b0;
    step();
    chk_out("prerst", 8'd1, 8'h61);
    reset = 1'b1;
    step();
    chk("mrst.valid",  32'(bus.out_valid), 32'd0);
    chk("mrst.addr",   32'(bus.imem_addr), 32'd0);
    chk("mrst.halted", 32'(bus.halted),    32'd0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_out("postrst", 8'd0, 8'h49);

`ifdef FETCH_JUMP_EN
    // forward jump +2 at pc 4, backward jump -2 at pc 7
    mem[4] = 8'hC2;
    mem[7] = 8'hFE;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'd4;
    step();
    bus.redirect = 1'b0;
    step();
    chk_out("jfwd", 8'd4, 8'hC2);
    step();
    chk_out("jtgt", 8'd7, 8'hFE);
    step();
    chk_out("jback", 8'd6, 8'h16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
